uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Downstream consumer of the TX fifo. Pops one byte at a time from the fifo
//  read port and serializes it onto the UART line: start bit, LSB-first data,
//  optional parity, then 1 or 2 stop bits. Baud timing comes from an internal
//  clock-cycle counter. Single clock domain; the fifo and this block share clk.
// PARAMETERS
//  DATA_WIDTH   8    data bits per frame; must match the fifo width
//  CLKS_PER_BIT 868  clk cycles per UART bit (100 MHz / 115200); must be >= 2
//  PARITY_EN    0    1 = insert a parity bit after the data bits
//  PARITY_ODD   0    0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
//  STOP_BITS    1    number of stop bits; only 1 or 2 are legal
// PORTS
//  clk         in   1           system clock, rising edge
//  rst         in   1           asynchronous reset, active high
//  tx_en       in   1           1 = new frames may start; 0 = hold in IDLE
//  fifo_data   in   DATA_WIDTH  fifo head entry; valid while fifo_empty=0
//  fifo_empty  in   1           fifo empty flag
//  fifo_rd_en  out  1           one-cycle pop strobe to the fifo
//  tx          out  1           serial line; idle level is 1
//  busy        out  1           1 from the pop cycle until frame end
//  tx_done     out  1           one-cycle pulse on the last clk of the final stop bit
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, tx=1, busy=0, tx_done=0, fifo_rd_en=0,
//    bit counter=0, baud counter=0. An in-flight byte is dropped; it is already popped.
//  - FSM states: IDLE, START, DATA, PARITY, STOP.
//  - IDLE: tx=1. fifo_rd_en = tx_en & ~fifo_empty (combinational, IDLE only).
//    On that same edge: latch fifo_data into the shift register, compute parity,
//    and go to START. busy rises on the next cycle.
//  - The fifo is show-ahead. fifo_data is the head entry before the pop edge.
//  - START: tx=0 for CLKS_PER_BIT cycles. Then go to DATA with bit index 0.
//  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after
//    each bit. After DATA_WIDTH bits, go to PARITY if PARITY_EN=1, else to STOP.
//  - PARITY: tx = ^data (even parity) or ~^data (odd parity), for CLKS_PER_BIT cycles.
//  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done=1 in the last cycle.
//    Then go to IDLE. busy falls on the edge that enters IDLE.
//  - Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and
//    wraps to 0 at each bit boundary. It is cleared on entry to START.
//  - Back-to-back frames: IDLE always lasts >= 1 cycle. Minimum gap is 1 clk of
//    extra idle-high. Frame period = (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT + 1.
//  - fifo_rd_en never asserts outside IDLE. It never asserts while fifo_empty=1.
//    There is at most one pop per frame.
//  - If tx_en drops mid-frame, the current frame completes and no new pop occurs.
//  - fifo_data changing mid-frame has no effect; only the latched copy is sent.
//  - tx is registered and glitch-free. Outputs tx, busy and tx_done come from flops.
// TESTING (CLKS_PER_BIT=4, DATA_WIDTH=8 unless noted)
//  1. Write 0xA5 with tx_en=1. fifo_rd_en pulses 1 clk. tx sequence is
//     0,1,0,1,0,0,1,0,1,1, each bit 4 clk. tx_done pulses once, at cycle 40
//     after the pop.
//  2. Load 3 bytes 0x00,0xFF,0x55. Expect exactly 3 pops and 3 frames,
//     41 clk apart. Expect 1 idle clk between frames, then busy=0 and tx=1.
//  3. Set PARITY_EN=1, PARITY_ODD=0, byte 0x07. Parity bit=1, frame 11 bits.
//     With PARITY_ODD=1 the parity bit=0.
//  4. Set STOP_BITS=2. Stop phase lasts 8 clk. tx_done pulses at cycle 44 after the pop.
//  5. Keep fifo_empty=1, or tx_en=0 with fifo_empty=0, for 100 clk.
//     Expect no fifo_rd_en, tx=1, busy=0.
//  6. Assert rst in the middle of DATA bit 3. tx=1 and busy=0 immediately.
//     After release, the next fifo byte is sent cleanly from START.

Source files
------------

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - fifo read port and UART line bundle for the TX serializer
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_en;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic                  tx;
    logic                  busy;
    logic                  tx_done;

    modport master (
        output tx_en, fifo_data, fifo_empty,
        input  fifo_rd_en, tx, busy, tx_done
    );

    modport slave (
        input  tx_en, fifo_data, fifo_empty,
        output fifo_rd_en, tx, busy, tx_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - pops bytes from a show-ahead fifo and shifts them out as UART frames
module uart_tx_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_serializer_if.slave   bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q;
    logic [CW-1:0]         baud_q;
    logic [CW-1:0]         baud_d;
    logic [IW-1:0]         bit_q;
    logic                  stop_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic                  par_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  done_d;
    logic                  pop;
    logic                  bit_end;
    logic                  last_stop;

    // Gated by rst so no pop can be requested while the block is held in reset.
    assign pop       = (state_q == IDLE) & bus.tx_en & ~bus.fifo_empty & ~rst;
    assign bit_end   = (baud_q == CW'(CLKS_PER_BIT - 1));
    assign baud_d    = bit_end ? '0 : baud_q + 1'b1;
    assign shift_d   = shift_q >> 1;
    assign last_stop = (STOP_BITS == 1) | stop_q;
    // Registered one cycle early so the pulse lines up with the final stop-bit clock.
    assign done_d    = (state_q == STOP) & last_stop & (baud_q == CW'(CLKS_PER_BIT - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (pop) begin
                        shift_q <= bus.fifo_data;
                        par_q   <= (PARITY_ODD != 0) ? ~^bus.fifo_data : ^bus.fifo_data;
                        bit_q   <= '0;
                        stop_q  <= 1'b0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        if (bit_q == IW'(DATA_WIDTH - 1)) begin
                            if (PARITY_EN != 0) begin
                                tx_q    <= par_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_d;
                            tx_q    <= shift_d[0];
                        end
                    end
                end
                PARITY: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        if (last_stop) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.fifo_rd_en = pop;
    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.tx_done    = done_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench over three serializer configurations
module tb_uart_tx_serializer;
    localparam int CPB = 4;
    localparam logic [2:0] P_EN  = 3'b110;
    localparam logic [2:0] P_ODD = 3'b100;
    localparam logic [2:0] TWO_S = 3'b010;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic       wr_valid;
    logic [7:0] wr_byte;
    logic       tx_w   [3];
    logic       busy_w [3];
    logic       rd_w   [3];
    logic       idle_w [3];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, g, $time, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop 1s.
    function automatic void build_frame(input logic [7:0] d, input int pen, input int odd,
                                        input int stops, output logic [11:0] f, output int len);
        int ones;
        ones = $countones(d);
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        len = 9;
        if (pen != 0) begin
            f[9] = ((ones % 2) != 0) ^ (odd != 0);
            len++;
        end
        len += stops;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int PEN   = int'(P_EN[g]);
        localparam int PODD  = int'(P_ODD[g]);
        localparam int STOPS = TWO_S[g] ? 2 : 1;

        uart_tx_serializer_if #(.DATA_WIDTH(8)) bus ();

        uart_tx_serializer #(
            .DATA_WIDTH  (8),
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (PEN),
            .PARITY_ODD  (PODD),
            .STOP_BITS   (STOPS)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );

        logic [7:0]  fq [$];
        logic [7:0]  sb [$];
        bit          pop_pending = 0;
        logic        idle_l = 1'b1;
        logic        in_frame;
        logic [11:0] frame;
        int          flen;
        int          idx;

        assign bus.tx_en = tx_en;
        assign tx_w[g]   = bus.tx;
        assign busy_w[g] = bus.busy;
        assign rd_w[g]   = bus.fifo_rd_en;
        assign idle_w[g] = idle_l;

        // Show-ahead fifo model; updates land just after the edge.
        initial begin
            bus.fifo_empty = 1'b1;
            bus.fifo_data  = '0;
            forever begin
                @(posedge clk);
                #1;
                if (pop_pending) begin
                    void'(fq.pop_front());
                    pop_pending = 0;
                end
                if (wr_valid) begin
                    fq.push_back(wr_byte);
                    sb.push_back(wr_byte);
                end
                bus.fifo_empty = (fq.size() == 0);
                bus.fifo_data  = (fq.size() == 0) ? 8'($urandom) : fq[0];
            end
        end

        // Monitor: pops expected byte on each fifo pop and checks the frame cycle by cycle.
        initial begin
            logic [7:0] exp_b;
            in_frame = 1'b0;
            idx      = 0;
            flen     = 0;
            frame    = '1;
            forever begin
                @(negedge clk);
                if (rst) begin
                    in_frame = 1'b0;
                    chk("rst_tx", g, 32'(bus.tx), 32'd1);
                    chk("rst_busy", g, 32'(bus.busy), 32'd0);
                    chk("rst_done", g, 32'(bus.tx_done), 32'd0);
                    chk("rst_rd_en", g, 32'(bus.fifo_rd_en), 32'd0);
                end else if (in_frame) begin
                    chk("tx_bit", g, 32'(bus.tx), 32'(frame[idx/CPB]));
                    chk("busy_frame", g, 32'(bus.busy), 32'd1);
                    chk("tx_done", g, 32'(bus.tx_done), 32'(idx == flen*CPB - 1));
                    chk("rd_en_in_frame", g, 32'(bus.fifo_rd_en), 32'd0);
                    idx++;
                    if (idx == flen*CPB) in_frame = 1'b0;
                end else begin
                    chk("idle_tx", g, 32'(bus.tx), 32'd1);
                    chk("idle_busy", g, 32'(bus.busy), 32'd0);
                    chk("idle_done", g, 32'(bus.tx_done), 32'd0);
                    chk("pop_rule", g, 32'(bus.fifo_rd_en), 32'(tx_en & ~bus.fifo_empty));
                    if (bus.fifo_rd_en) begin
                        chk("pop_has_data", g, 32'(sb.size() != 0), 32'd1);
                        if (sb.size() != 0) begin
                            exp_b = sb.pop_front();
                            chk("pop_data", g, 32'(bus.fifo_data), 32'(exp_b));
                            build_frame(exp_b, PEN, PODD, STOPS, frame, flen);
                            in_frame    = 1'b1;
                            idx         = 0;
                            pop_pending = 1;
                        end
                    end
                end
                idle_l = !in_frame && (sb.size() == 0) && (fq.size() == 0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_byte  = b;
        wr_valid = 1'b1;
        step(1);
        wr_valid = 1'b0;
    endtask

    function automatic logic all_idle();
        return idle_w[0] & idle_w[1] & idle_w[2];
    endfunction

    task automatic wait_idle(input int budget);
        step(3);
        for (int k = 0; k < budget; k++) begin
            if (all_idle()) break;
            step(1);
        end
        chk("drain_done", 99, 32'(all_idle()), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        tx_en    = 1'b0;
        wr_valid = 1'b0;
        wr_byte  = '0;
        step(3);
        rst = 1'b0;
        step(2);

        tx_en = 1'b1;
        write_byte(8'hA5);
        wait_idle(200);

        write_byte(8'h00);
        write_byte(8'hFF);
        write_byte(8'h55);
        wait_idle(400);

        write_byte(8'h07);
        wait_idle(200);

        // Disabled with data waiting: no pop may happen.
        tx_en = 1'b0;
        write_byte(8'h3C);
        write_byte(8'hC3);
        step(100);
        tx_en = 1'b1;
        wait_idle(400);

        // Quiet line with empty fifo.
        step(100);

        repeat (60) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5)      write_byte(8'($urandom));
            else if (r < 7) tx_en = 1'($urandom_range(0, 1));
            else            step($urandom_range(1, 60));
        end
        tx_en = 1'b1;
        wait_idle(4000);

        // Reset in the middle of data bit 3.
        write_byte(8'h96);
        for (int k = 0; k < 20; k++) begin
            if (rd_w[0]) break;
            step(1);
        end
        chk("pop_seen", 0, 32'(rd_w[0]), 32'd1);
        step(18);
        rst = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("rst_async_tx", g, 32'(tx_w[g]), 32'd1);
            chk("rst_async_busy", g, 32'(busy_w[g]), 32'd0);
        end
        step(2);
        rst = 1'b0;
        step(2);
        write_byte(8'h4B);
        wait_idle(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
